// File: rtl/mor1kx_dbus_bridge_wb_pkg.sv
// Shared encodings for the LSU-to-Wishbone data bus bridge.
// State codes and fixed classic-cycle tags.
package mor1kx_dbus_bridge_wb_pkg;

  localparam logic [1:0] OR1K_DBUS_IDLE  = 2'd0;
  localparam logic [1:0] OR1K_DBUS_BUSY  = 2'd1;
  localparam logic [1:0] OR1K_DBUS_RETRY = 2'd2;
  localparam logic [1:0] OR1K_DBUS_DRAIN = 2'd3;

  localparam logic [2:0] OR1K_DBUS_CTI = 3'b111;
  localparam logic [1:0] OR1K_DBUS_BTE = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = OR1K_DBUS_IDLE,
    S_BUSY  = OR1K_DBUS_BUSY,
    S_RETRY = OR1K_DBUS_RETRY,
    S_DRAIN = OR1K_DBUS_DRAIN
  } dbus_state_e;

endpackage

// File: rtl/mor1kx_bus_watchdog.sv
// Bus cycle watchdog: flags a cycle that has been open
// for BUS_TIMEOUT cycles. A zero timeout removes it.
module mor1kx_bus_watchdog #(
  parameter int BUS_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (BUS_TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(BUS_TIMEOUT - 1);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if (clear)
        cnt <= '0;
      else if (enable && !expired)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mor1kx_dbus_bridge_wb.sv
// LSU data bus to Wishbone B3 classic bridge with
// retry, flush drain and watchdog-forced bus errors.
module mor1kx_dbus_bridge_wb
  import mor1kx_dbus_bridge_wb_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BUS_TIMEOUT          = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dbus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  input  logic [3:0]                      dbus_bsel_i,
  input  logic                            dbus_we_i,
  input  logic                            pipeline_flush_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_o,
  output logic [3:0]                      wbm_sel_o,
  output logic                            wbm_we_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i
);

  dbus_state_e state, state_nxt;
  logic start, ack_p, err_p, expired;

  mor1kx_bus_watchdog #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (state != S_IDLE),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_p     = 1'b0;
    err_p     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dbus_req_i && !pipeline_flush_i) begin
          state_nxt = S_BUSY;
          start     = 1'b1;
        end
      end
      S_BUSY: begin
        // err outranks ack; a flush silences the LSU pulse
        if (wbm_err_i || wbm_ack_i) begin
          state_nxt = S_IDLE;
          err_p     = wbm_err_i && !pipeline_flush_i;
          ack_p     = !wbm_err_i && !pipeline_flush_i;
        end else if (expired) begin
          state_nxt = S_IDLE;
          err_p     = !pipeline_flush_i;
        end else if (pipeline_flush_i) begin
          state_nxt = S_DRAIN;
        end else if (wbm_rty_i) begin
          state_nxt = S_RETRY;
        end
      end
      S_RETRY: begin
        if (expired) begin
          state_nxt = S_IDLE;
          err_p     = !pipeline_flush_i;
        end else if (pipeline_flush_i) begin
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_BUSY;
        end
      end
      S_DRAIN: begin
        if (wbm_ack_i || wbm_err_i || wbm_rty_i || expired)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
      wbm_we_o   <= 1'b0;
      dbus_ack_o <= 1'b0;
      dbus_err_o <= 1'b0;
      dbus_dat_o <= '0;
    end else begin
      state      <= state_nxt;
      wbm_cyc_o  <= state_nxt != S_IDLE;
      wbm_stb_o  <= (state_nxt == S_BUSY) ||
                    (state_nxt == S_DRAIN);
      dbus_ack_o <= ack_p;
      dbus_err_o <= err_p;
      if (start) begin
        wbm_adr_o <= dbus_adr_i;
        wbm_dat_o <= dbus_dat_i;
        wbm_sel_o <= dbus_bsel_i;
        wbm_we_o  <= dbus_we_i;
      end
      if (ack_p)
        dbus_dat_o <= wbm_dat_i;
    end
  end

  assign wbm_cti_o = OR1K_DBUS_CTI;
  assign wbm_bte_o = OR1K_DBUS_BTE;

endmodule

// File: tb/tb_mor1kx_dbus_bridge_wb.sv
// Bench for the data bus bridge: vector table plus
// hand sequences for flush, timeout and reset.
module tb_mor1kx_dbus_bridge_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbus_req_i = 1'b0;
  logic [31:0] dbus_adr_i = '0;
  logic [31:0] dbus_dat_i = '0;
  logic [3:0]  dbus_bsel_i = '0;
  logic        dbus_we_i = 1'b0;
  logic        pipeline_flush_i = 1'b0;
  logic        dbus_ack_o, dbus_err_o;
  logic [31:0] dbus_dat_o, wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_rty_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  always #5 clk = ~clk;

  mor1kx_dbus_bridge_wb #(
    .OPTION_OPERAND_WIDTH(32),
    .BUS_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i),
    .dbus_dat_i(dbus_dat_i), .dbus_bsel_i(dbus_bsel_i),
    .dbus_we_i(dbus_we_i),
    .pipeline_flush_i(pipeline_flush_i),
    .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o),
    .dbus_dat_o(dbus_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
  );

  // rsp: 0 ack, 1 err, 2 err+ack, 3 ack+rty
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          waits;
    bit          rty_first;
    int          rsp;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {dbus_ack_o, dbus_err_o, dbus_dat_o,
            wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
            wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o};
  endfunction

  logic [127:0] reset_outs;
  assign reset_outs = {108'd0, 3'b111, 2'b00};

  // scoreboard consumer
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && (dbus_ack_o || dbus_err_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse",
              {dbus_ack_o, dbus_err_o}, 2'b00);
      end else begin
        m_e = sb.pop_front();
        check("rsp_kind", {dbus_ack_o, dbus_err_o},
              m_e.is_err ? 2'b01 : 2'b10);
        check("rsp_dat", dbus_dat_o, m_e.dat);
      end
    end
  end

  task automatic clr_rsp();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
  endtask

  task automatic push_exp(input bit is_err,
                          input logic [31:0] rd);
    exp_t e;
    e.is_err = is_err;
    e.dat    = is_err ? last_rdata : rd;
    sb.push_back(e);
    if (!is_err) last_rdata = rd;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int stbc = 0;
    int lat = -1;
    @(negedge clk);
    dbus_req_i  = 1'b1;
    dbus_adr_i  = v.adr;
    dbus_dat_i  = v.dat;
    dbus_bsel_i = v.sel;
    dbus_we_i   = v.we;
    wbm_dat_i   = v.rdata;
    push_exp(v.rsp == 1 || v.rsp == 2, v.rdata);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      clr_rsp();
      if (dbus_ack_o || dbus_err_o) begin
        lat = n;
        dbus_req_i = 1'b0;
        check({tag, "_cyc_end"}, wbm_cyc_o, 1'b0);
      end else if (wbm_cyc_o && !wbm_stb_o) begin
        check({tag, "_rty_gap"}, stbc, 1);
      end else if (wbm_stb_o) begin
        check({tag, "_bus"},
              {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o},
              {v.adr, v.dat, v.sel, v.we});
        if (v.rty_first && stbc == 0) begin
          wbm_rty_i = 1'b1;
        end else if (stbc == v.waits) begin
          wbm_ack_i = v.rsp != 1;
          wbm_err_i = v.rsp == 1 || v.rsp == 2;
          wbm_rty_i = v.rsp == 3;
        end
        stbc++;
      end
    end
    dbus_req_i = 1'b0;
    clr_rsp();
    check({tag, "_latency"}, lat, v.lat);
    repeat (2) @(negedge clk);
    check({tag, "_no_reissue"},
          {wbm_cyc_o, wbm_stb_o, dbus_ack_o}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int stbc;
    int cycc;
    bit done;

    vecs[0] = '{32'h100, 32'h0, 4'hf, 1'b0, 0, 1'b0, 0,
                32'hDEADBEEF, 2};
    vecs[1] = '{32'h204, 32'h12341234, 4'b0011, 1'b1, 3,
                1'b0, 0, 32'h0, 5};
    vecs[2] = '{32'h300, 32'h0, 4'hf, 1'b0, 1, 1'b1, 0,
                32'hCAFEF00D, 4};
    vecs[3] = '{32'h400, 32'h0, 4'b1100, 1'b0, 1, 1'b0, 1,
                32'h11112222, 3};
    vecs[4] = '{32'h008, 32'hA5A5A5A5, 4'hf, 1'b1, 2,
                1'b0, 2, 32'h33334444, 4};
    vecs[5] = '{32'h00C, 32'h0, 4'hf, 1'b0, 0, 1'b0, 3,
                32'h55AA55AA, 2};

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), reset_outs);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", all_outs(), reset_outs);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // flush during a 5-wait access
    @(negedge clk);
    dbus_req_i = 1'b1;
    dbus_adr_i = 32'h500;
    dbus_we_i  = 1'b0;
    dbus_bsel_i = 4'hf;
    wbm_dat_i  = 32'h0BADF00D;
    stbc = 0;
    done = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      clr_rsp();
      pipeline_flush_i = (n == 2);
      if (n == 2) dbus_req_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (stbc == 5) wbm_ack_i = 1'b1;
        stbc++;
      end else if (stbc > 0) begin
        done = 1'b1;
      end
    end
    pipeline_flush_i = 1'b0;
    clr_rsp();
    check("flush_cyc_held", stbc, 6);
    @(negedge clk);
    check("flush_no_pulse",
          {wbm_cyc_o, dbus_ack_o, dbus_err_o}, 3'b000);
    check("flush_dat_kept", dbus_dat_o, last_rdata);
    run_vec(vecs[0], "post_flush");

    // silent slave trips the watchdog
    @(negedge clk);
    dbus_req_i = 1'b1;
    dbus_adr_i = 32'h600;
    push_exp(1'b1, 32'h0);
    cycc = 0;
    done = 1'b0;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(negedge clk);
      if (wbm_cyc_o) cycc++;
      if (dbus_err_o || dbus_ack_o) begin
        done = 1'b1;
        dbus_req_i = 1'b0;
      end
    end
    dbus_req_i = 1'b0;
    check("tmo_pulse_seen", done, 1'b1);
    check("tmo_cyc_cycles", cycc, 16);
    @(negedge clk);
    check("tmo_single_err",
          {dbus_err_o, wbm_cyc_o}, 2'b00);

    // reset while BUSY
    @(negedge clk);
    dbus_req_i = 1'b1;
    dbus_adr_i = 32'h700;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", {wbm_cyc_o, wbm_stb_o}, 2'b11);
    rst_n = 1'b0;
    dbus_req_i = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", all_outs(), reset_outs);
    rst_n = 1'b1;
    last_rdata = '0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h99999999;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    check("rst_late_ack1", all_outs(), reset_outs);
    @(negedge clk);
    check("rst_late_ack2", all_outs(), reset_outs);

    run_vec(vecs[5], "post_reset");

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
